bsc_mmu_dmem_arbiter: RTL and testbench

Shares the single data-cache request port of the MMU between `NUM_PORTS` page-table-walker-style requesters that use `ptw_dmem_comm_t` / `dmem_ptw_comm_t`. It sits between the PTW instances (e.g. instruction-side and data-side walkers) and the dcache adapter. It round-robin arbitrates, latches the winning request so the downstream request stays stable until accepted, and keeps exactly one transaction outstanding. It routes the response back to the owning requester only, optionally protected by a response watchdog.

---
 rtl/bsc_mmu_dmem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_bsc_mmu_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsc_mmu_dmem_arbiter.sv
// Round-robin arbiter sharing one dcache request port among NUM_PORTS walkers, one transaction in flight.
// Optional response watchdog with nack + DRAIN state when MMU_DMEM_ARB_TIMEOUT_EN is defined.
package bsc_mmu_dmem_pkg;
  typedef struct packed {
    logic        valid;
    logic [39:0] addr;
    logic [4:0]  cmd;
    logic [3:0]  typ;
    logic [63:0] data;
  } ptw_dmem_req_t;

  typedef struct packed {
    ptw_dmem_req_t req;
  } ptw_dmem_comm_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic        nack;
    logic        replay;
    logic        has_data;
  } dmem_ptw_resp_t;

  typedef struct packed {
    logic           dmem_ready;
    dmem_ptw_resp_t resp;
  } dmem_ptw_comm_t;
endpackage

module bsc_mmu_dmem_arbiter
  import bsc_mmu_dmem_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  ptw_dmem_comm_t [NUM_PORTS-1:0]   ptw_dmem_comm_i,
  output dmem_ptw_comm_t [NUM_PORTS-1:0]   dmem_ptw_comm_o,
  output ptw_dmem_comm_t                   ptw_dmem_comm_o,
  input  dmem_ptw_comm_t                   dmem_ptw_comm_i,
  output logic                             busy_o,
  output logic [OW-1:0]                    owner_o
);

  // state   | meaning
  // IDLE    | arbitrate; granted port sees dmem_ready
  // ISSUE   | latched request presented downstream until accepted
  // WAIT    | request accepted, waiting for the dcache response
  // DRAIN   | owner already nacked; swallow the late response (timeout build only)
`ifdef MMU_DMEM_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_e;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
`endif

  state_e        state_q;
  logic [OW-1:0] rr_ptr_q;
  logic [OW-1:0] owner_q;
  logic [39:0]   addr_q;
  logic [4:0]    cmd_q;
  logic [3:0]    typ_q;
  logic [63:0]   data_q;

  logic          gnt_found;
  logic [OW-1:0] gnt_idx;
  logic [OW-1:0] owner_nxt;

  // First valid port at or above rr_ptr, wrapping.
  always_comb begin
    logic [OW-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = OW'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!gnt_found && ptw_dmem_comm_i[cand].req.valid) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign owner_nxt = (owner_q == OW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      addr_q   <= '0;
      cmd_q    <= '0;
      typ_q    <= '0;
      data_q   <= '0;
`ifdef MMU_DMEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            addr_q  <= ptw_dmem_comm_i[gnt_idx].req.addr;
            cmd_q   <= ptw_dmem_comm_i[gnt_idx].req.cmd;
            typ_q   <= ptw_dmem_comm_i[gnt_idx].req.typ;
            data_q  <= ptw_dmem_comm_i[gnt_idx].req.data;
            owner_q <= gnt_idx;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (dmem_ptw_comm_i.dmem_ready) begin
            state_q <= S_WAIT;
`ifdef MMU_DMEM_ARB_TIMEOUT_EN
            cnt_q   <= TW'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        S_WAIT: begin
          if (dmem_ptw_comm_i.resp.valid) begin
            rr_ptr_q <= owner_nxt;
            state_q  <= S_IDLE;
          end
`ifdef MMU_DMEM_ARB_TIMEOUT_EN
          else if (cnt_q == '0) begin
            state_q <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
`endif
        end
`ifdef MMU_DMEM_ARB_TIMEOUT_EN
        S_DRAIN: begin
          if (dmem_ptw_comm_i.resp.valid) begin
            rr_ptr_q <= owner_nxt;
            state_q  <= S_IDLE;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Ready and response only ever reach a single port; everything else stays zero.
  always_comb begin
    dmem_ptw_comm_o = '0;
    if (rstn_i && state_q == S_IDLE && gnt_found) begin
      dmem_ptw_comm_o[gnt_idx].dmem_ready = 1'b1;
    end
    if (state_q == S_WAIT) begin
      if (dmem_ptw_comm_i.resp.valid) begin
        dmem_ptw_comm_o[owner_q].resp = dmem_ptw_comm_i.resp;
      end
`ifdef MMU_DMEM_ARB_TIMEOUT_EN
      else if (cnt_q == '0) begin
        dmem_ptw_comm_o[owner_q].resp.valid = 1'b1;
        dmem_ptw_comm_o[owner_q].resp.nack  = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    ptw_dmem_comm_o          = '0;
    ptw_dmem_comm_o.req.valid = (state_q == S_ISSUE);
    ptw_dmem_comm_o.req.addr  = addr_q;
    ptw_dmem_comm_o.req.cmd   = cmd_q;
    ptw_dmem_comm_o.req.typ   = typ_q;
    ptw_dmem_comm_o.req.data  = data_q;
  end

  assign busy_o  = (state_q != S_IDLE);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_bsc_mmu_dmem_arbiter.sv
// Directed bench for bsc_mmu_dmem_arbiter: vector table for single/stray/stall-by-row cases,
// plus hand-written round-robin, downstream stall, reset mid-op and (when compiled in) timeout sequences.
module tb_bsc_mmu_dmem_arbiter;
  import bsc_mmu_dmem_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  ptw_dmem_comm_t [1:0] up_req;
  dmem_ptw_comm_t [1:0] up_rsp;
  ptw_dmem_comm_t       ds_req;
  dmem_ptw_comm_t       ds_rsp;
  logic                 busy;
  logic [0:0]           owner;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bsc_mmu_dmem_arbiter #(.NUM_PORTS(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .ptw_dmem_comm_i (up_req),
    .dmem_ptw_comm_o (up_rsp),
    .ptw_dmem_comm_o (ds_req),
    .dmem_ptw_comm_i (ds_rsp),
    .busy_o          (busy),
    .owner_o         (owner)
  );

  typedef struct {
    logic        v0;   logic [39:0] a0;
    logic        v1;   logic [39:0] a1;
    logic        dsr;  logic        rsp_v; logic [63:0] rsp_d;
    logic        e_rdy0; logic e_rdy1; logic e_dsv; logic [39:0] e_dsa;
    logic        e_rv0;  logic e_rv1;  logic [63:0] e_d0; logic [63:0] e_d1;
    logic        e_busy; logic e_owner;
  } vec_t;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    up_req = '0;
    ds_rsp = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vt [14];
    logic [39:0] A;
    logic [63:0] D;
    logic [39:0] dsa_m;
    int hs;
    int exp_p;

    A = 40'h00_8000_1008;
    D = 64'hDEAD_BEEF_0000_0001;
    //          v0 a0 v1 a1      dsr rv rd       | rdy0 rdy1 dsv dsa     rv0 rv1 d0 d1      busy own
    vt[0]  = '{1, A, 0, 0,       1, 0, 0,         1, 0, 0, 0,         0, 0, 0, 0,        0, 0};
    vt[1]  = '{0, 0, 0, 0,       1, 0, 0,         0, 0, 1, A,         0, 0, 0, 0,        1, 0};
    vt[2]  = '{0, 0, 0, 0,       1, 0, 0,         0, 0, 0, 0,         0, 0, 0, 0,        1, 0};
    vt[3]  = '{0, 0, 0, 0,       1, 0, 0,         0, 0, 0, 0,         0, 0, 0, 0,        1, 0};
    vt[4]  = '{0, 0, 0, 0,       1, 0, 0,         0, 0, 0, 0,         0, 0, 0, 0,        1, 0};
    vt[5]  = '{0, 0, 0, 0,       1, 1, D,         0, 0, 0, 0,         1, 0, D, 0,        1, 0};
    vt[6]  = '{0, 0, 0, 0,       1, 0, 0,         0, 0, 0, 0,         0, 0, 0, 0,        0, 0};
    vt[7]  = '{0, 0, 0, 0,       0, 1, 64'h77,    0, 0, 0, 0,         0, 0, 0, 0,        0, 0};
    vt[8]  = '{0, 0, 1, 40'h100, 0, 1, 64'h77,    0, 1, 0, 0,         0, 0, 0, 0,        0, 0};
    vt[9]  = '{0, 0, 1, 40'h200, 0, 0, 0,         0, 0, 1, 40'h100,   0, 0, 0, 0,        1, 1};
    vt[10] = '{0, 0, 0, 0,       0, 1, 64'h77,    0, 0, 1, 40'h100,   0, 0, 0, 0,        1, 1};
    vt[11] = '{0, 0, 0, 0,       1, 0, 0,         0, 0, 1, 40'h100,   0, 0, 0, 0,        1, 1};
    vt[12] = '{0, 0, 0, 0,       1, 1, 64'h55,    0, 0, 0, 0,         0, 1, 0, 64'h55,   1, 1};
    vt[13] = '{0, 0, 0, 0,       0, 0, 0,         0, 0, 0, 0,         0, 0, 0, 0,        0, 1};

    // Reset: outputs zero and ready suppressed even with a valid requester.
    rstn = 1'b0;
    clr();
    repeat (2) @(negedge clk);
    up_req[0].req.valid = 1'b1;
    #1;
    chk("reset_up_rsp", 192'(up_rsp), 192'(0));
    chk("reset_ds_req", 192'(ds_req), 192'(0));
    chk("reset_busy_owner", {190'(0), busy, owner}, 192'(0));
    @(negedge clk);
    clr();
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      clr();
      up_req[0].req.valid = vt[i].v0;  up_req[0].req.addr = vt[i].a0;
      up_req[1].req.valid = vt[i].v1;  up_req[1].req.addr = vt[i].a1;
      ds_rsp.dmem_ready   = vt[i].dsr;
      ds_rsp.resp.valid   = vt[i].rsp_v;
      ds_rsp.resp.data    = vt[i].rsp_d;
      #1;
      dsa_m = ds_req.req.valid ? ds_req.req.addr : 40'h0;
      chk($sformatf("vec%0d", i),
          {15'(0), up_rsp[0].dmem_ready, up_rsp[1].dmem_ready, ds_req.req.valid, dsa_m,
           up_rsp[0].resp.valid, up_rsp[1].resp.valid, up_rsp[0].resp.data, up_rsp[1].resp.data,
           busy, owner},
          {15'(0), vt[i].e_rdy0, vt[i].e_rdy1, vt[i].e_dsv, vt[i].e_dsa,
           vt[i].e_rv0, vt[i].e_rv1, vt[i].e_d0, vt[i].e_d1, vt[i].e_busy, vt[i].e_owner});
    end

    // Round-robin: both ports held valid, grants must alternate starting at port0.
    for (int k = 0; k < 4; k++) begin
      exp_p = k % 2;
      @(negedge clk);
      clr();
      up_req[0].req.valid = 1'b1; up_req[0].req.addr = 40'h400;
      up_req[1].req.valid = 1'b1; up_req[1].req.addr = 40'h401;
      ds_rsp.dmem_ready = 1'b1;
      #1;
      chk($sformatf("rr%0d_grant", k), {190'(0), up_rsp[1].dmem_ready, up_rsp[0].dmem_ready},
          192'(1 << exp_p));
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_owner_addr", k), {150'(0), owner, ds_req.req.valid, ds_req.req.addr},
          {150'(0), 1'(exp_p), 1'b1, 40'h400 + 40'(exp_p)});
      @(negedge clk);
      ds_rsp.resp.valid = 1'b1;
      ds_rsp.resp.data  = 64'(k + 16);
      #1;
      chk($sformatf("rr%0d_resp", k),
          {60'(0), up_rsp[1].dmem_ready, up_rsp[0].dmem_ready, up_rsp[1].resp.valid,
           up_rsp[0].resp.valid, (exp_p == 1) ? up_rsp[1].resp.data : up_rsp[0].resp.data, 64'(0)},
          {60'(0), 2'b00, (exp_p == 1) ? 2'b10 : 2'b01, 64'(k + 16), 64'(0)});
    end

    // Downstream stall: latched address holds while upstream changes; one handshake total.
    hs = 0;
    @(negedge clk);
    clr();
    up_req[0].req.valid = 1'b1; up_req[0].req.addr = 40'h1000;
    #1;
    chk("stall_grant", {190'(0), up_rsp[1].dmem_ready, up_rsp[0].dmem_ready}, 192'(1));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clr();
      up_req[0].req.valid = 1'b1; up_req[0].req.addr = 40'h2000 + 40'(i * 8);
      ds_rsp.dmem_ready = (i == 5);
      #1;
      if (ds_req.req.valid && ds_rsp.dmem_ready) hs++;
      chk($sformatf("stall_hold%0d", i), {151'(0), ds_req.req.valid, ds_req.req.addr},
          {151'(0), 1'b1, 40'h1000});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clr();
      ds_rsp.dmem_ready = 1'b1;
      ds_rsp.resp.valid = (i == 2);
      ds_rsp.resp.data  = 64'hCAFE;
      #1;
      if (ds_req.req.valid && ds_rsp.dmem_ready) hs++;
    end
    chk("stall_resp", {127'(0), up_rsp[0].resp.valid, up_rsp[0].resp.data}, {127'(0), 1'b1, 64'hCAFE});
    chk("stall_handshakes", 192'(hs), 192'(1));

    // Reset in WAIT (port1 owner), late response afterwards must be dropped, next grant port0.
    @(negedge clk);
    clr();
    up_req[1].req.valid = 1'b1; up_req[1].req.addr = 40'h300;
    #1;
    chk("rst_pre_grant", {190'(0), up_rsp[1].dmem_ready, up_rsp[0].dmem_ready}, 192'(2));
    @(negedge clk);
    clr();
    ds_rsp.dmem_ready = 1'b1;
    @(negedge clk);
    clr();
    #1;
    chk("rst_pre_wait", {190'(0), busy, owner}, 192'(3));
    #1;
    rstn = 1'b0;
    up_req[0].req.valid = 1'b1;
    up_req[1].req.valid = 1'b1;
    #1;
    chk("rst_mid_outputs", {1'b0, 191'(up_rsp)} | 192'(ds_req) | {190'(0), busy, owner}, 192'(0));
    @(negedge clk);
    #1;
    chk("rst_mid_outputs2", {1'b0, 191'(up_rsp)} | 192'(ds_req) | {190'(0), busy, owner}, 192'(0));
    @(negedge clk);
    rstn = 1'b1;
    ds_rsp.resp.valid = 1'b1;
    ds_rsp.resp.data  = 64'h99;
    #1;
    chk("rst_late_dropped", {190'(0), up_rsp[1].resp.valid, up_rsp[0].resp.valid}, 192'(0));
    chk("rst_next_grant", {190'(0), up_rsp[1].dmem_ready, up_rsp[0].dmem_ready}, 192'(1));
    @(negedge clk);
    clr();
    ds_rsp.dmem_ready = 1'b1;
    #1;
    chk("rst_next_owner", {191'(0), owner}, 192'(0));
    @(negedge clk);
    clr();
    ds_rsp.resp.valid = 1'b1;
    ds_rsp.resp.data  = 64'hAB;
    #1;
    chk("rst_next_resp", {127'(0), up_rsp[0].resp.valid, up_rsp[0].resp.data}, {127'(0), 1'b1, 64'hAB});

`ifdef MMU_DMEM_ARB_TIMEOUT_EN
    // Watchdog: nack on WAIT cycle 16, DRAIN swallows late response, then IDLE.
    @(negedge clk);
    clr();
    up_req[1].req.valid = 1'b1; up_req[1].req.addr = 40'h500;
    #1;
    chk("to_grant", {190'(0), up_rsp[1].dmem_ready, up_rsp[0].dmem_ready}, 192'(2));
    @(negedge clk);
    clr();
    ds_rsp.dmem_ready = 1'b1;
    for (int w = 1; w <= 16; w++) begin
      @(negedge clk);
      clr();
      #1;
      chk($sformatf("to_wait%0d", w),
          {123'(0), up_rsp[0].resp.valid, up_rsp[1].resp.valid, up_rsp[1].resp.nack,
           up_rsp[1].resp.data, busy},
          {123'(0), 1'b0, (w == 16), (w == 16), 64'(0), 1'b1});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clr();
      up_req[0].req.valid = 1'b1;
      ds_rsp.resp.valid = (i == 2);
      ds_rsp.resp.data  = 64'h77;
      #1;
      chk($sformatf("to_drain%0d", i),
          {187'(0), busy, up_rsp[0].dmem_ready, up_rsp[1].dmem_ready,
           up_rsp[0].resp.valid, up_rsp[1].resp.valid},
          {187'(0), 1'b1, 4'b0000});
    end
    @(negedge clk);
    clr();
    up_req[0].req.valid = 1'b1;
    #1;
    chk("to_idle", {190'(0), busy, up_rsp[0].dmem_ready}, 192'(1));
`endif

    @(negedge clk);
    clr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
